// File: rtl/jtag_bridge_pkg.sv
// Shared constants for the JTAG debug bridge: opcodes, engine states and
// the bit layout of the word returned for DR capture.
package jtag_bridge_pkg;

  localparam logic [3:0] OP_CTRL  = 4'd0;
  localparam logic [3:0] OP_ADDR  = 4'd1;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_UPOP  = 4'd3;
  localparam logic [3:0] OP_READ  = 4'd4;
  localparam logic [3:0] OP_STAT  = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  localparam int RSP_CPU_BIT   = 0;
  localparam int RSP_OVR_BIT   = 1;
  localparam int RSP_DROP_LSB  = 8;
  localparam int RSP_VALID_BIT = 8;
  localparam int RSP_CNT_LSB   = 16;

endpackage

// File: rtl/jtag_bridge_byte_fifo.sv
// Byte-wide console FIFO. Full/empty come from the registered count, so a
// push is judged against the occupancy before any same-cycle pop.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    dout     = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is only read where count marks it valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jtag_bridge.sv
// Clock-side debug engine: executes synchroniser commands for CPU reset,
// memory access with auto-increment, status and console FIFO draining.
module jtag_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int ADDR_STEP  = 2,
  parameter int UART_CH    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [3:0]           cmd_op,
  input  logic [DW-1:0]        cmd_data,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy,
  output logic                 cpu_reset,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_ack,
  input  logic [8*UART_CH-1:0] uart_tx,
  input  logic [UART_CH-1:0]   uart_we,
  output logic [UART_CH-1:0]   uart_full
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e               state_q, state_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]        rsp_q, rsp_d;
  logic                 ovr_q, ovr_d;
  logic [UART_CH-1:0]   drop_q, drop_d;

  logic [UART_CH-1:0]   fifo_full, fifo_empty, fifo_pop;
  logic [7:0]           fifo_dout [UART_CH];
  logic [CW-1:0]        fifo_count [UART_CH];

  logic                 cmd_accept, upop_cmd, stat_clr, ch_ok, sel_empty;
  logic [2:0]           uart_ch;
  logic [7:0]           sel_byte;
  logic [CW-1:0]        sel_cnt;

  for (genvar g = 0; g < UART_CH; g++) begin : g_fifo
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (reset),
      .push  (uart_we[g]),
      .pop   (fifo_pop[g]),
      .din   (uart_tx[8*g +: 8]),
      .dout  (fifo_dout[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .count (fifo_count[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // cmd_valid has no ready: a strobe outside IDLE is lost and flagged OVR.
  // mem_we/mem_re are held until mem_ack; the ack cycle completes the access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_op == OP_WRITE)     state_d = WR;
        else if (cmd_valid && cmd_op == OP_READ) state_d = RD;
      end
      WR, RD:  if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we    = (state_q == WR);
    mem_re    = (state_q == RD);
    busy      = (state_q != IDLE);
    cpu_reset = cpu_reset_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    rsp_data  = rsp_q;
    uart_full = fifo_full;
  end

  always_comb begin
    cmd_accept = cmd_valid && (state_q == IDLE);
    upop_cmd   = cmd_accept && (cmd_op == OP_UPOP);
    uart_ch    = cmd_data[2:0];
    ch_ok      = ({1'b0, uart_ch} < 4'(UART_CH));
    sel_byte   = '0;
    sel_cnt    = '0;
    sel_empty  = 1'b1;
    fifo_pop   = '0;
    for (int i = 0; i < UART_CH; i++) begin
      if (uart_ch == 3'(i)) begin
        sel_byte    = fifo_dout[i];
        sel_cnt     = fifo_count[i];
        sel_empty   = fifo_empty[i];
        fifo_pop[i] = upop_cmd;
      end
    end

    cpu_reset_d = cpu_reset_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_d       = rsp_q;
    stat_clr    = 1'b0;
    if (cmd_accept) begin
      case (cmd_op)
        OP_CTRL:  cpu_reset_d = cmd_data[0];
        OP_ADDR:  mem_addr_d  = cmd_data[AW-1:0];
        OP_WRITE: mem_wdata_d = cmd_data;
        OP_UPOP: begin
          rsp_d = '0;
          if (ch_ok && !sel_empty) begin
            rsp_d[RSP_CNT_LSB +: CW] = sel_cnt - CW'(1);
            rsp_d[RSP_VALID_BIT]     = 1'b1;
            rsp_d[7:0]               = sel_byte;
          end
        end
        OP_STAT: begin
          rsp_d                          = '0;
          rsp_d[RSP_DROP_LSB +: UART_CH] = drop_q;
          rsp_d[RSP_OVR_BIT]             = ovr_q;
          rsp_d[RSP_CPU_BIT]             = cpu_reset_q;
          stat_clr                       = 1'b1;
        end
        default: ;
      endcase
    end

    if (state_q != IDLE && mem_ack) begin
      mem_addr_d = mem_addr_q + AW'(ADDR_STEP);
      if (state_q == RD) rsp_d = mem_rdata;
    end

    // A flag raised in the same cycle as the STAT clear survives.
    ovr_d  = (stat_clr ? 1'b0 : ovr_q) | (cmd_valid && state_q != IDLE);
    drop_d = (stat_clr ? '0 : drop_q) | (uart_we & fifo_full);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_reset_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_q       <= '0;
      ovr_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      cpu_reset_q <= cpu_reset_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_q       <= rsp_d;
      ovr_q       <= ovr_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: tb/tb_jtag_bridge.sv
// Self-checking bench for jtag_bridge with two 4-deep console channels:
// vector table, directed corner sequences and a randomized model-checked run.
module tb_jtag_bridge;
  import jtag_bridge_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int STEP = 2;
  localparam int NCH  = 2;
  localparam int DEP  = 4;

  logic            clk, rst;
  logic            cmd_valid;
  logic [3:0]      cmd_op;
  logic [DW-1:0]   cmd_data, rsp_data, mem_wdata, mem_rdata;
  logic            busy, cpu_reset, mem_we, mem_re, mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [8*NCH-1:0] uart_tx;
  logic [NCH-1:0]  uart_we, uart_full;

  jtag_bridge #(.AW(AW), .DW(DW), .ADDR_STEP(STEP), .UART_CH(NCH), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_data(rsp_data), .busy(busy), .cpu_reset(cpu_reset), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .uart_tx(uart_tx), .uart_we(uart_we), .uart_full(uart_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model of the bridge's visible state
  logic          m_cpu, m_ovr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rsp, m_wdata;
  logic [NCH-1:0] m_drop;
  logic [7:0]    m_mem [NCH][DEP];
  int            m_n [NCH];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] data;
    logic          exp_cpu;
    logic [DW-1:0] exp_rsp;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    m_cpu = 0; m_ovr = 0; m_addr = '0; m_rsp = '0; m_wdata = '0; m_drop = '0;
    for (int c = 0; c < NCH; c++) m_n[c] = 0;
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " rsp"}, rsp_data, m_rsp);
    check({tag, " cpu_reset"}, cpu_reset, m_cpu);
    check({tag, " mem_addr"}, mem_addr, m_addr);
    check({tag, " busy"}, busy, 1'b0);
    for (int c = 0; c < NCH; c++)
      check($sformatf("%s uart_full[%0d]", tag, c), uart_full[c], m_n[c] == DEP);
  endtask

  // one cycle with an optional non-memory command and an optional push
  task automatic step(input bit do_cmd, input logic [3:0] op, input logic [DW-1:0] data,
                      input bit do_push, input int pch, input logic [7:0] pb, input string tag);
    bit full_before;
    int c;
    @(negedge clk);
    cmd_valid = do_cmd; cmd_op = op; cmd_data = data;
    uart_we = '0;
    uart_tx = NCH*8'($urandom);
    if (do_push) begin
      uart_we[pch] = 1'b1;
      uart_tx[pch*8 +: 8] = pb;
    end
    full_before = do_push && (m_n[pch] == DEP);
    if (do_cmd) begin
      case (op)
        OP_CTRL: m_cpu = data[0];
        OP_ADDR: m_addr = data[AW-1:0];
        OP_UPOP: begin
          c = int'(data[2:0]);
          m_rsp = '0;
          if (c < NCH && m_n[c] > 0) begin
            m_rsp[7:0] = m_mem[c][0];
            for (int k = 0; k < DEP-1; k++) m_mem[c][k] = m_mem[c][k+1];
            m_n[c]--;
            m_rsp[8] = 1'b1;
            m_rsp = m_rsp | (DW'(m_n[c]) << 16);
          end
        end
        OP_STAT: begin
          m_rsp = '0;
          m_rsp[8 +: NCH] = m_drop;
          m_rsp[1] = m_ovr;
          m_rsp[0] = m_cpu;
          m_ovr = 0;
          m_drop = '0;
        end
        default: ;
      endcase
    end
    if (do_push) begin
      if (full_before) m_drop[pch] = 1'b1;
      else begin
        m_mem[pch][m_n[pch]] = pb;
        m_n[pch]++;
      end
    end
    @(negedge clk);
    cmd_valid = 0; uart_we = '0;
    check_idle_outputs(tag);
  endtask

  // memory access with a bus responder acking after lat extra cycles
  task automatic access(input bit is_read, input logic [DW-1:0] data, input int lat,
                        input logic [DW-1:0] rdata, input bit inject, input string tag);
    @(negedge clk);
    cmd_valid = 1; cmd_op = is_read ? OP_READ : OP_WRITE; cmd_data = data;
    if (is_read) exp_q.push_back(rdata);
    else m_wdata = data;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i <= lat; i++) begin
      check({tag, " mem_we"}, mem_we, !is_read);
      check({tag, " mem_re"}, mem_re, is_read);
      check({tag, " busy"}, busy, 1'b1);
      check({tag, " addr"}, mem_addr, m_addr);
      check({tag, " wdata"}, mem_wdata, m_wdata);
      if (inject && i == 0 && lat > 0) begin
        cmd_valid = 1; cmd_op = OP_WRITE; cmd_data = ~data;
        m_ovr = 1;
      end
      if (i == lat) begin
        mem_ack = 1; mem_rdata = rdata;
      end
      @(negedge clk);
      cmd_valid = 0; mem_ack = 0; mem_rdata = $urandom;
    end
    m_addr = m_addr + AW'(STEP);
    if (is_read) m_rsp = exp_q.pop_front();
    check({tag, " we_done"}, mem_we, 1'b0);
    check({tag, " re_done"}, mem_re, 1'b0);
    check({tag, " wdata_done"}, mem_wdata, m_wdata);
    check_idle_outputs(tag);
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = '0; cmd_data = '0; mem_rdata = '0; mem_ack = 0;
    uart_tx = '0; uart_we = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check("reset rsp", rsp_data, 0);
    check("reset cpu_reset", cpu_reset, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_re", mem_re, 0);
    check("reset busy", busy, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset uart_full", uart_full, 0);
    rst = 0;

    // vector table: command -> cpu_reset, rsp_data, mem_addr
    vecs[0]  = '{OP_CTRL,  32'h1,         1'b1, 32'h0, 32'h0};
    vecs[1]  = '{OP_STAT,  32'h0,         1'b1, 32'h1, 32'h0};
    vecs[2]  = '{OP_ADDR,  32'h1234_5678, 1'b1, 32'h1, 32'h1234_5678};
    vecs[3]  = '{4'd5,     32'hFFFF,      1'b1, 32'h1, 32'h1234_5678};
    vecs[4]  = '{OP_CTRL,  32'h0,         1'b0, 32'h1, 32'h1234_5678};
    vecs[5]  = '{OP_STAT,  32'h0,         1'b0, 32'h0, 32'h1234_5678};
    vecs[6]  = '{OP_UPOP,  32'h7,         1'b0, 32'h0, 32'h1234_5678};
    vecs[7]  = '{OP_CTRL,  32'h3,         1'b1, 32'h0, 32'h1234_5678};
    vecs[8]  = '{OP_STAT,  32'h0,         1'b1, 32'h1, 32'h1234_5678};
    vecs[9]  = '{4'd7,     32'h1,         1'b1, 32'h1, 32'h1234_5678};
    vecs[10] = '{OP_CTRL,  32'h2,         1'b0, 32'h1, 32'h1234_5678};
    vecs[11] = '{OP_ADDR,  32'h0,         1'b0, 32'h1, 32'h0};
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      cmd_valid = 1; cmd_op = vecs[v].op; cmd_data = vecs[v].data;
      @(negedge clk);
      cmd_valid = 0;
      check($sformatf("vec%0d cpu_reset", v), cpu_reset, vecs[v].exp_cpu);
      check($sformatf("vec%0d rsp", v), rsp_data, vecs[v].exp_rsp);
      check($sformatf("vec%0d addr", v), mem_addr, vecs[v].exp_addr);
    end
    m_cpu = vecs[11].exp_cpu; m_rsp = vecs[11].exp_rsp; m_addr = vecs[11].exp_addr;

    // write with ack three cycles late
    step(1, OP_ADDR, 32'h100, 0, 0, 8'h0, "addr100");
    access(0, 32'hDEAD_BEEF, 3, '0, 0, "write");
    check("write addr step", mem_addr, 32'h102);
    check("write wdata", mem_wdata, 32'hDEAD_BEEF);

    // read with immediate ack wraps the address
    step(1, OP_ADDR, 32'hFFFF_FFFE, 0, 0, 8'h0, "addrwrap");
    access(1, '0, 0, 32'h1234, 0, "read_wrap");
    check("read rsp", rsp_data, 32'h1234);
    check("read wrap addr", mem_addr, 32'h0);

    // command while a read is pending is dropped and flagged
    access(1, '0, 2, 32'h5555_AAAA, 1, "read_ovr");
    step(1, OP_STAT, '0, 0, 0, 8'h0, "stat_ovr1");
    check("stat ovr set", rsp_data[1], 1'b1);
    step(1, OP_STAT, '0, 0, 0, 8'h0, "stat_ovr2");
    check("stat ovr clear", rsp_data[1], 1'b0);

    // overfill channel 1
    for (int b = 0; b < 5; b++) step(0, OP_CTRL, '0, 1, 1, 8'hA0 + 8'(b), "push_ch1");
    check("ch1 full", uart_full[1], 1'b1);
    step(1, OP_UPOP, 32'h1, 0, 0, 8'h0, "upop_ch1");
    check("upop ch1 word", rsp_data, 32'h0003_01A0);
    step(1, OP_UPOP, 32'h0, 0, 0, 8'h0, "upop_ch0_empty");
    check("upop ch0 valid", rsp_data[8], 1'b0);
    step(1, OP_STAT, '0, 0, 0, 8'h0, "stat_drop1");
    check("stat drop1", rsp_data[9], 1'b1);

    // push on full with same-cycle pop, then push+pop on empty
    for (int b = 0; b < 4; b++) step(0, OP_CTRL, '0, 1, 0, 8'h10 + 8'(b), "fill_ch0");
    step(1, OP_UPOP, 32'h0, 1, 0, 8'h77, "full_pushpop");
    check("full_pushpop word", rsp_data, 32'h0003_0110);
    for (int b = 0; b < 3; b++) step(1, OP_UPOP, 32'h0, 0, 0, 8'h0, "drain_ch0");
    step(1, OP_UPOP, 32'h0, 1, 0, 8'h55, "empty_pushpop");
    check("empty_pushpop word", rsp_data, 32'h0);
    step(1, OP_UPOP, 32'h0, 0, 0, 8'h0, "empty_pushpop_after");
    check("empty_pushpop byte", rsp_data, 32'h0000_0155);

    // drop set during a STAT clear survives
    for (int b = 0; b < 4; b++) step(0, OP_CTRL, '0, 1, 1, 8'h30 + 8'(b), "fill_ch1");
    step(1, OP_STAT, '0, 1, 1, 8'h99, "stat_setwins");
    step(1, OP_STAT, '0, 0, 0, 8'h0, "stat_after_setwins");
    check("setwins drop1", rsp_data[9], 1'b1);

    // randomized run against the model
    for (int it = 0; it < 300; it++) begin
      int kind;
      kind = $urandom_range(0, 7);
      case (kind)
        0: step(0, OP_CTRL, '0, 1, $urandom_range(0, NCH-1), 8'($urandom), "rnd_push");
        1: step(1, OP_UPOP, DW'($urandom_range(0, 3)), 0, 0, 8'h0, "rnd_upop");
        2: step(1, OP_STAT, '0, $urandom_range(0, 1), $urandom_range(0, NCH-1), 8'($urandom), "rnd_stat");
        3: access(0, $urandom, $urandom_range(0, 3), '0, 1'($urandom), "rnd_write");
        4: access(1, $urandom, $urandom_range(0, 3), $urandom, 1'($urandom), "rnd_read");
        5: step(1, OP_ADDR, $urandom, 0, 0, 8'h0, "rnd_addr");
        6: step(1, OP_CTRL, $urandom, 1, $urandom_range(0, NCH-1), 8'($urandom), "rnd_ctrl");
        default: step(1, OP_UPOP, DW'($urandom_range(0, 1)), 1, $urandom_range(0, NCH-1),
                      8'($urandom), "rnd_pushpop");
      endcase
    end

    // reset in the middle of a write access
    step(1, OP_CTRL, 32'h1, 0, 0, 8'h0, "ctrl1");
    step(0, OP_CTRL, '0, 1, 0, 8'hEE, "push_before_rst");
    @(negedge clk);
    cmd_valid = 1; cmd_op = OP_WRITE; cmd_data = 32'hCAFE_F00D;
    @(negedge clk);
    cmd_valid = 0;
    check("pre-reset mem_we", mem_we, 1'b1);
    rst = 1;
    #1;
    check("rst cpu_reset", cpu_reset, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst mem_addr", mem_addr, 0);
    check("rst uart_full", uart_full, 0);
    check("rst rsp", rsp_data, 0);
    @(negedge clk);
    rst = 0;
    reset_model();
    for (int c = 0; c < NCH; c++) step(1, OP_UPOP, DW'(c), 0, 0, 8'h0, "rst_fifo_empty");
    step(1, OP_STAT, '0, 0, 0, 8'h0, "rst_stat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
